// File: rtl/tlc_phase_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlc_phase_sequencer_if : strobe/sensor/flash inputs and lamp outputs      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface tlc_phase_sequencer_if;
   logic       tick_i;
   logic       sensor_i;
   logic       flash_i;
   logic [2:0] light_highway;
   logic [2:0] light_farm;
   logic [2:0] phase_o;
   logic       req_pending_o;

   modport master (
      output tick_i, sensor_i, flash_i,
      input  light_highway, light_farm, phase_o, req_pending_o
   );

   modport slave (
      input  tick_i, sensor_i, flash_i,
      output light_highway, light_farm, phase_o, req_pending_o
   );
endinterface
`default_nettype wire

// File: rtl/tlc_phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlc_phase_sequencer : timed highway/farm phase sequencer with debounced   |
// | farm sensor, request latch and maintenance flash. Rev 1.0                 |
// +--------------------------------------------------------------------------+
module tlc_phase_sequencer #(
   parameter int CNT_W        = 8,
   parameter int T_MIN_GREEN  = 10,
   parameter int T_YELLOW     = 3,
   parameter int T_ALL_RED    = 1,
   parameter int T_FARM_GREEN = 8,
   parameter int DEB_CYCLES   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tlc_phase_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_HG    = 3'd0,
      S_HY    = 3'd1,
      S_AR1   = 3'd2,
      S_FG    = 3'd3,
      S_FY    = 3'd4,
      S_AR2   = 3'd5,
      S_FLASH = 3'd6
   } state_t;

   localparam int               c_deb_w     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_e_max     = '1;
   localparam logic [CNT_W-1:0] c_min_green = CNT_W'(T_MIN_GREEN);
   localparam logic [CNT_W-1:0] c_yel_last  = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] c_fg_last   = CNT_W'(T_FARM_GREEN - 1);
   localparam logic [CNT_W-1:0] c_ar_last   = CNT_W'((T_ALL_RED > 0) ? T_ALL_RED - 1 : 0);
   localparam bit               c_skip_ar   = (T_ALL_RED == 0);

   logic               sync1_q, sync2_q;
   logic               db_q, db_d;
   logic [c_deb_w-1:0] deb_cnt_q, deb_cnt_d;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   e_q, e_d;
   logic               req_q, req_d;
   logic               blink_q, blink_d;
   logic [2:0]         lh_q, lf_q;

   function automatic logic [5:0] f_lamps(input state_t s, input logic b);
      case (s)
         S_HG:    f_lamps = 6'b001_100;
         S_HY:    f_lamps = 6'b010_100;
         S_FG:    f_lamps = 6'b100_001;
         S_FY:    f_lamps = 6'b100_010;
         S_FLASH: f_lamps = b ? 6'b010_100 : 6'b000_000;
         default: f_lamps = 6'b100_100;
      endcase
   endfunction

   always_comb begin
      // Debounce: a full run of DEB_CYCLES differing samples flips the value.
      db_d      = db_q;
      deb_cnt_d = '0;
      if (sync2_q != db_q) begin
         if (deb_cnt_q == c_deb_last) db_d = ~db_q;
         else                         deb_cnt_d = deb_cnt_q + 1'b1;
      end

      state_d = state_q;
      blink_d = blink_q;
      case (state_q)
         S_HG:
            if ((req_q && (e_q >= c_min_green)) || bus.flash_i) state_d = S_HY;
         S_HY:
            if (bus.tick_i && (e_q == c_yel_last))
               state_d = c_skip_ar ? (bus.flash_i ? S_FLASH : S_FG) : S_AR1;
         S_AR1:
            if (bus.tick_i && (e_q == c_ar_last)) state_d = bus.flash_i ? S_FLASH : S_FG;
         S_FG:
            if (bus.flash_i || (bus.tick_i && (e_q == c_fg_last))) state_d = S_FY;
         S_FY:
            if (bus.tick_i && (e_q == c_yel_last))
               state_d = c_skip_ar ? (bus.flash_i ? S_FLASH : S_HG) : S_AR2;
         S_AR2:
            if (bus.tick_i && (e_q == c_ar_last)) state_d = bus.flash_i ? S_FLASH : S_HG;
         S_FLASH:
            if (!bus.flash_i)     state_d = c_skip_ar ? S_HG : S_AR2;
            else if (bus.tick_i)  blink_d = ~blink_q;
         default:
            state_d = S_HG;
      endcase

      // Ticks landing on a transition belong to neither phase.
      if (state_d != state_q) begin
         e_d = '0;
         if (state_d == S_FLASH) blink_d = 1'b1;
      end else if (bus.tick_i && (e_q != c_e_max)) begin
         e_d = e_q + 1'b1;
      end else begin
         e_d = e_q;
      end

      if ((state_d == S_FG) && (state_q != S_FG)) req_d = 1'b0;
      else if (db_q && (state_q != S_FG))         req_d = 1'b1;
      else                                        req_d = req_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         deb_cnt_q <= '0;
         state_q   <= S_HG;
         e_q       <= '0;
         req_q     <= 1'b0;
         blink_q   <= 1'b1;
         lh_q      <= 3'b001;
         lf_q      <= 3'b100;
      end else begin
         sync1_q      <= bus.sensor_i;
         sync2_q      <= sync1_q;
         db_q         <= db_d;
         deb_cnt_q    <= deb_cnt_d;
         state_q      <= state_d;
         e_q          <= e_d;
         req_q        <= req_d;
         blink_q      <= blink_d;
         {lh_q, lf_q} <= f_lamps(state_d, blink_d);
      end
   end

   assign bus.light_highway = lh_q;
   assign bus.light_farm    = lf_q;
   assign bus.phase_o       = state_q;
   assign bus.req_pending_o = req_q;

endmodule
`default_nettype wire
